// File: rtl/hex_display_pkg.sv
// Shared types and the hex glyph table for the seven-segment display controller.
package hex_display_pkg;

  // Active-low segment vector, bit order {g,f,e,d,c,b,a}.
  typedef logic [6:0] seg_t;

  // All segments off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Standard hex glyph table (active-low).
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_render.sv
// Combinational single-digit renderer: nibble plus blank flag to segment pattern.
module hex_digit_render
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  // Blank overrides the glyph lookup.
  assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: static per-digit bus plus an
// anode-scanned single bus, with leading-zero blanking and blinking.
//
// Handshake: load is a single-cycle strobe with no ready; value is captured on
// every rising edge where load=1, and there is no back-pressure.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   hex_all,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int SCAN_W  = cnt_width(SCAN_CYCLES);
  localparam int BLINK_W = cnt_width(BLINK_CYCLES);
  localparam int IDX_W   = cnt_width(DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] disp;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                visible;

  logic [DIGITS-1:0]   zero_above;
  logic [DIGITS-1:0]   digit_blank;
  seg_t                rendered [DIGITS];
  logic [7*DIGITS-1:0] hex_next;
  seg_t                scan_seg;
  logic [DIGITS-1:0]   an_next;

  // Display register: captures value on load, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp <= '0;
    end else if (load) begin
      disp <= value;
    end
  end

  // Scan divider and digit index; index advances on the divider's terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timer; parked at zero and visible while disabled so enabling starts
  // with a full visible half-period.
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      visible   <= ~visible;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Per-digit blank flags: hidden blink phase, or a leading zero above digit 0.
  always_comb begin
    logic run;
    run         = 1'b1;
    zero_above  = '0;
    digit_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run            = run & (disp[4*i +: 4] == 4'h0);
      zero_above[i]  = run;
      digit_blank[i] = ~visible | (blank_lz & zero_above[i] & (i != 0));
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex_digit_render u_render (
      .nibble (disp[4*g +: 4]),
      .blank  (digit_blank[g]),
      .seg    (rendered[g])
    );
  end

  // Pack the static bus and select the scanned digit and its anode.
  always_comb begin
    hex_next = '0;
    scan_seg = SEG_BLANK;
    an_next  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      hex_next[7*i +: 7] = rendered[i];
      if (idx == IDX_W'(i)) begin
        scan_seg   = rendered[i];
        an_next[i] = 1'b0;
      end
    end
  end

  // Output registers; reset drives everything dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_all <= '1;
      seg     <= SEG_BLANK;
      an      <= '1;
    end else begin
      hex_all <= hex_next;
      seg     <= scan_seg;
      an      <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with DIGITS=4, SCAN_CYCLES=4, BLINK_CYCLES=16.
module tb_hex_display_ctrl;

  localparam logic [27:0] ALL_DARK  = 28'hFFFFFFF;
  localparam logic [27:0] ALL_ZEROS = {4{7'h40}};

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        blink_en;
  logic [27:0] hex_all;
  logic [6:0]  seg;
  logic [3:0]  an;

  int pass_cnt   = 0;
  int check_cnt  = 0;
  int fail_cnt   = 0;
  int scan_edges = 0;

  logic [6:0]  glyph  [16];
  logic [15:0] ld_val [5];
  logic [27:0] ld_exp [5];

  hex_display_ctrl #(
    .DIGITS       (4),
    .SCAN_CYCLES  (4),
    .BLINK_CYCLES (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .hex_all  (hex_all),
    .seg      (seg),
    .an       (an)
  );

  // Clock and safety net.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // One rising edge, then settle; counts edges since reset was released.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) scan_edges = 0;
    else       scan_edges++;
  endtask

  // Scan index expected on the outputs after the latest edge.
  function automatic int exp_idx();
    return ((scan_edges - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << exp_idx());
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    ld_val = '{16'h1234, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    ld_exp = '{{7'h79, 7'h24, 7'h30, 7'h19},
               {7'h40, 7'h79, 7'h24, 7'h30},
               {7'h19, 7'h12, 7'h02, 7'h78},
               {7'h00, 7'h10, 7'h08, 7'h03},
               {7'h27, 7'h21, 7'h06, 7'h0E}};

    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;

    // Reset state.
    tick();
    tick();
    check("reset_hex_all", hex_all, ALL_DARK);
    check("reset_seg", {21'd0, seg}, 28'h7F);
    check("reset_an", {24'd0, an}, 28'hF);

    // First edge after release renders zeros on digit 0.
    reset = 1'b0;
    tick();
    check("first_hex_all", hex_all, ALL_ZEROS);
    check("first_seg", {21'd0, seg}, 28'h40);
    check("first_an", {24'd0, an}, 28'hE);

    // Glyph table through loads; old value visible the load edge, new one after.
    for (int k = 0; k < 5; k++) begin
      load  = 1'b1;
      value = ld_val[k];
      tick();
      check("load_latency", hex_all, (k == 0) ? ALL_ZEROS : ld_exp[k-1]);
      load = 1'b0;
      tick();
      check("load_glyphs", hex_all, ld_exp[k]);
      check("load_an", {24'd0, an}, {24'd0, exp_an()});
      check("load_seg", {21'd0, seg}, {21'd0, glyph[ld_val[k][4*exp_idx() +: 4]]});
    end

    // Scan sequence from a fresh reset with ABCD.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b1;
    value = 16'hABCD;
    tick();
    check("scan_start_an", {24'd0, an}, 28'hE);
    check("scan_start_seg", {21'd0, seg}, 28'h40);
    load = 1'b0;
    for (int n = 2; n <= 20; n++) begin
      tick();
      check("scan_an", {24'd0, an}, {24'd0, exp_an()});
      check("scan_seg", {21'd0, seg}, {21'd0, glyph[value[4*exp_idx() +: 4]]});
    end
    check("scan_wrap_an", {24'd0, an}, 28'hE);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load     = 1'b1;
    value    = 16'h0040;
    tick();
    load = 1'b0;
    tick();
    check("lz_0040", hex_all, {7'h7F, 7'h7F, 7'h19, 7'h40});
    load  = 1'b1;
    value = 16'h0400;
    tick();
    load = 1'b0;
    tick();
    check("lz_0400", hex_all, {7'h7F, 7'h19, 7'h40, 7'h40});
    load  = 1'b1;
    value = 16'h0000;
    tick();
    load = 1'b0;
    tick();
    check("lz_0000", hex_all, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    blank_lz = 1'b0;
    tick();
    check("lz_off", hex_all, ALL_ZEROS);

    // Blink: 16 visible edges, 16 dark, repeating; scanning continues.
    blink_en = 1'b1;
    for (int m = 1; m <= 52; m++) begin
      tick();
      if ((m >= 17 && m <= 32) || m >= 49) begin
        check("blink_dark_hex", hex_all, ALL_DARK);
        check("blink_dark_seg", {21'd0, seg}, 28'h7F);
      end else begin
        check("blink_show_hex", hex_all, ALL_ZEROS);
        check("blink_show_seg", {21'd0, seg}, 28'h40);
      end
      check("blink_an", {24'd0, an}, {24'd0, exp_an()});
    end
    blink_en = 1'b0;
    tick();
    check("blink_off_lag", hex_all, ALL_DARK);
    tick();
    check("blink_off_show", hex_all, ALL_ZEROS);

    // Reset wins over a simultaneous load, mid-scan.
    tick();
    reset = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    tick();
    check("rst_load_hex", hex_all, ALL_DARK);
    check("rst_load_seg", {21'd0, seg}, 28'h7F);
    check("rst_load_an", {24'd0, an}, 28'hF);
    reset = 1'b0;
    load  = 1'b0;
    tick();
    check("post_rst_an", {24'd0, an}, 28'hE);
    check("post_rst_seg", {21'd0, seg}, 28'h40);
    check("post_rst_hex", hex_all, ALL_ZEROS);
    tick();
    check("post_rst_disp", hex_all, ALL_ZEROS);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
